// File: rtl/lcd_rx_monitor_if.sv
// rtl/lcd_rx_monitor_if.sv - RGB565 LCD receive pins and monitor status bundle
interface lcd_rx_monitor_if;
  logic        LCD_DE;
  logic        LCD_HSYNC;
  logic        LCD_VSYNC;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic        ERR_CLR;
  logic        FRAME_DONE;
  logic        FRAME_OK;
  logic [11:0] LINE_LEN;
  logic [11:0] LINE_TOTAL;
  logic [15:0] CHECKSUM;
  logic [15:0] FRAME_CNT;
  logic        LOCKED;
  logic        ERR_STICKY;

  modport master (
    output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, ERR_CLR,
    input  FRAME_DONE, FRAME_OK, LINE_LEN, LINE_TOTAL, CHECKSUM, FRAME_CNT, LOCKED, ERR_STICKY
  );

  // HSYNC is carried for completeness; lines are delimited by DE alone.
  modport slave (
    input  LCD_DE, LCD_VSYNC, LCD_R, LCD_G, LCD_B, ERR_CLR,
    output FRAME_DONE, FRAME_OK, LINE_LEN, LINE_TOTAL, CHECKSUM, FRAME_CNT, LOCKED, ERR_STICKY
  );
endinterface

// File: rtl/lcd_rx_monitor.sv
// rtl/lcd_rx_monitor.sv - LCD receive checker: line/frame geometry, checksum, lock
module lcd_rx_monitor #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_POL   = 0,
  parameter int LOCK_FRAMES = 3
) (
  input logic             CLK,
  input logic             RST,
  lcd_rx_monitor_if.slave bus
);
  localparam logic [11:0] H_LEN    = 12'(H_ACTIVE);
  localparam logic [11:0] V_LEN    = 12'(V_ACTIVE);
  localparam logic [3:0]  LOCK_CNT = 4'(LOCK_FRAMES);
  localparam logic        VS_ACT   = (VSYNC_POL != 0);

  typedef enum logic {SEEK, ACTIVE} state_t;

  logic        de_s1_q, de_s2_q, vs_s1_q, vs_s2_q, clr_s1_q;
  logic [15:0] rgb_s1_q;

  state_t      state_q, state_d;
  logic [11:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic        line_err_q, line_err_d;
  logic [15:0] line_sum_q, line_sum_d, frame_sum_q, frame_sum_d;
  logic [3:0]  good_q, good_d;
  logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic [11:0] line_len_q, line_len_d, line_total_q, line_total_d;
  logic [15:0] checksum_q, checksum_d, frame_cnt_q, frame_cnt_d;
  logic        locked_q, locked_d, err_sticky_q, err_sticky_d;

  logic        vs_edge, de_fall, err_tot, frame_ok;
  logic [11:0] lines_tot;
  logic [15:0] sum_tot;
  logic [3:0]  good_inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      de_s1_q  <= 1'b0;
      de_s2_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      clr_s1_q <= 1'b0;
      rgb_s1_q <= '0;
    end else begin
      de_s1_q  <= bus.LCD_DE;
      de_s2_q  <= de_s1_q;
      vs_s1_q  <= (bus.LCD_VSYNC == VS_ACT);
      vs_s2_q  <= vs_s1_q;
      clr_s1_q <= bus.ERR_CLR;
      rgb_s1_q <= {bus.LCD_R, bus.LCD_G, bus.LCD_B};
    end
  end

  // A DE fall coinciding with the frame close is folded into the closing frame.
  assign vs_edge   = vs_s1_q & ~vs_s2_q;
  assign de_fall   = ~de_s1_q & de_s2_q;
  assign lines_tot = (de_fall && line_cnt_q != 12'hFFF) ? line_cnt_q + 12'd1 : line_cnt_q;
  assign err_tot   = line_err_q | (de_fall & (pix_cnt_q != H_LEN));
  assign sum_tot   = frame_sum_q + (de_fall ? line_sum_q : 16'd0);
  assign frame_ok  = ~err_tot & (lines_tot == V_LEN) & ~de_s1_q & ~de_s2_q;
  assign good_inc  = (good_q == LOCK_CNT) ? good_q : good_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    line_err_d   = line_err_q;
    line_sum_d   = line_sum_q;
    frame_sum_d  = frame_sum_q;
    good_d       = good_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    line_len_d   = line_len_q;
    line_total_d = line_total_q;
    checksum_d   = checksum_q;
    frame_cnt_d  = frame_cnt_q;
    locked_d     = locked_q;
    err_sticky_d = clr_s1_q ? 1'b0 : err_sticky_q;

    case (state_q)
      SEEK: begin
        if (vs_edge) begin
          state_d     = ACTIVE;
          pix_cnt_d   = '0;
          line_cnt_d  = '0;
          line_err_d  = 1'b0;
          line_sum_d  = '0;
          frame_sum_d = '0;
        end
      end
      ACTIVE: begin
        if (vs_edge) begin
          frame_done_d = 1'b1;
          frame_ok_d   = frame_ok;
          line_total_d = lines_tot;
          checksum_d   = sum_tot;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          if (de_fall) line_len_d = pix_cnt_q;
          if (frame_ok) begin
            good_d   = good_inc;
            locked_d = (good_inc == LOCK_CNT);
          end else begin
            good_d       = '0;
            locked_d     = 1'b0;
            err_sticky_d = 1'b1;
          end
          // Pixels of a line still open at the close are dropped with it.
          pix_cnt_d   = '0;
          line_cnt_d  = '0;
          line_err_d  = 1'b0;
          line_sum_d  = '0;
          frame_sum_d = '0;
        end else begin
          if (de_s1_q) begin
            if (pix_cnt_q != 12'hFFF) pix_cnt_d = pix_cnt_q + 12'd1;
            line_sum_d = line_sum_q + rgb_s1_q;
            if (vs_s1_q) line_err_d = 1'b1;
          end
          if (de_fall) begin
            line_len_d  = pix_cnt_q;
            line_cnt_d  = lines_tot;
            line_err_d  = err_tot;
            frame_sum_d = sum_tot;
            pix_cnt_d   = '0;
            line_sum_d  = '0;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= SEEK;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_err_q   <= 1'b0;
      line_sum_q   <= '0;
      frame_sum_q  <= '0;
      good_q       <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      line_len_q   <= '0;
      line_total_q <= '0;
      checksum_q   <= '0;
      frame_cnt_q  <= '0;
      locked_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_err_q   <= line_err_d;
      line_sum_q   <= line_sum_d;
      frame_sum_q  <= frame_sum_d;
      good_q       <= good_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      line_len_q   <= line_len_d;
      line_total_q <= line_total_d;
      checksum_q   <= checksum_d;
      frame_cnt_q  <= frame_cnt_d;
      locked_q     <= locked_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.FRAME_DONE = frame_done_q;
  assign bus.FRAME_OK   = frame_ok_q;
  assign bus.LINE_LEN   = line_len_q;
  assign bus.LINE_TOTAL = line_total_q;
  assign bus.CHECKSUM   = checksum_q;
  assign bus.FRAME_CNT  = frame_cnt_q;
  assign bus.LOCKED     = locked_q;
  assign bus.ERR_STICKY = err_sticky_q;
endmodule

// File: tb/tb_lcd_rx_monitor.sv
// tb/tb_lcd_rx_monitor.sv - randomized frame stimulus against a frame-level reference model
module tb_lcd_rx_monitor;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int LK = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #15 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_rx_monitor_if bus ();

  lcd_rx_monitor #(
    .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(0), .LOCK_FRAMES(LK)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic        ok;
    logic [11:0] len;
    logic [11:0] total;
    logic [15:0] sum;
    logic [15:0] fc;
    logic        locked;
    logic        sticky;
  } exp_t;

  exp_t expq[$];
  exp_t e;

  bit   seek;
  int   m_fc, m_good, m_len;
  bit   m_locked, m_sticky;
  int   cur_lines, cur_sum;
  bit   cur_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      check("frame_done", bus.FRAME_DONE, 1);
      check("frame_ok", bus.FRAME_OK, e.ok);
      check("line_len", bus.LINE_LEN, e.len);
      check("line_total", bus.LINE_TOTAL, e.total);
      check("checksum", bus.CHECKSUM, e.sum);
      check("frame_cnt", bus.FRAME_CNT, e.fc);
      check("locked", bus.LOCKED, e.locked);
      check("err_sticky", bus.ERR_STICKY, e.sticky);
    end else begin
      check("frame_done_idle", bus.FRAME_DONE, 0);
    end
  end

  task automatic drive(input logic de, input logic vs, input logic clr, input logic [15:0] px);
    bus.LCD_DE    = de;
    bus.LCD_HSYNC = ~de;
    bus.LCD_VSYNC = vs;
    bus.ERR_CLR   = clr;
    {bus.LCD_R, bus.LCD_G, bus.LCD_B} = px;
  endtask

  task automatic model_reset();
    seek = 1; m_fc = 0; m_good = 0; m_len = 0; m_locked = 0; m_sticky = 0;
    cur_lines = 0; cur_sum = 0; cur_err = 0;
    expq.delete();
  endtask

  // Frame close seen from the pins: summary of the lines terminated since the last close.
  task automatic model_close(input bit open_line);
    exp_t x;
    bit   ok;
    if (seek) begin
      seek = 0;
    end else begin
      ok   = !cur_err && cur_lines == V && !open_line;
      m_fc = (m_fc + 1) & 16'hFFFF;
      if (ok) begin
        if (m_good < LK) m_good++;
        m_locked = (m_good == LK);
      end else begin
        m_good = 0; m_locked = 0; m_sticky = 1;
      end
      x.cyc = cyc + 2;  x.ok = ok;  x.len = 12'(m_len);
      x.total = 12'((cur_lines > 4095) ? 4095 : cur_lines);
      x.sum = cur_sum[15:0];  x.fc = 16'(m_fc);
      x.locked = m_locked;  x.sticky = m_sticky;
      expq.push_back(x);
    end
    cur_lines = 0; cur_sum = 0; cur_err = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(0, 1, 0, 16'($urandom));
      @(negedge clk);
    end
  endtask

  task automatic line(input int len, input int pv);
    logic [15:0] px;
    for (int i = 0; i < len; i++) begin
      px = (pv < 0) ? 16'($urandom) : 16'(pv);
      drive(1, 1, 0, px);
      cur_sum += px;
      @(negedge clk);
    end
    cur_lines++;
    if (len != H) cur_err = 1;
    m_len = len;
  endtask

  task automatic close_frame(input bit clr);
    drive(0, 0, clr, 16'($urandom));
    if (clr) m_sticky = 0;
    model_close(0);
    @(negedge clk);
    drive(0, 0, 0, 16'($urandom));
    @(negedge clk);
    drive(0, 1, 0, 16'($urandom));
  endtask

  task automatic frame(input int nl, input int pv, input int short_idx, input bit clr);
    idle(2);
    for (int l = 0; l < nl; l++) begin
      line((l == short_idx) ? H - 1 : H, pv);
      idle($urandom_range(1, 3));
    end
    idle(2);
    close_frame(clr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, bus.FRAME_DONE, 0);
    check({tag, "_ok"}, bus.FRAME_OK, 0);
    check({tag, "_len"}, bus.LINE_LEN, 0);
    check({tag, "_total"}, bus.LINE_TOTAL, 0);
    check({tag, "_sum"}, bus.CHECKSUM, 0);
    check({tag, "_fc"}, bus.FRAME_CNT, 0);
    check({tag, "_locked"}, bus.LOCKED, 0);
    check({tag, "_sticky"}, bus.ERR_STICKY, 0);
  endtask

  initial begin
    int nl, len;
    logic [15:0] px;
    rst = 1;
    drive(0, 1, 0, 16'h0);
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;
    idle(3);

    // Three frames of unit pixels: the first sync only arms the monitor.
    idle(2);
    line(H, 1);
    idle(2);
    close_frame(0);
    frame(V, 1, -1, 0);
    frame(V, 1, -1, 0);
    idle(2);
    check("t1_ok", bus.FRAME_OK, 1);
    check("t1_len", bus.LINE_LEN, 8);
    check("t1_total", bus.LINE_TOTAL, 4);
    check("t1_sum", bus.CHECKSUM, 16'h0020);
    check("t1_fc", bus.FRAME_CNT, 2);
    check("t1_locked", bus.LOCKED, 1);

    // Short line mid-frame; ERR_CLR coincides with the bad close.
    frame(V, -1, 1, 1);
    idle(2);
    check("t2_ok", bus.FRAME_OK, 0);
    check("t2_len", bus.LINE_LEN, 8);
    check("t2_sticky", bus.ERR_STICKY, 1);
    check("t2_locked", bus.LOCKED, 0);

    frame(V + 1, -1, -1, 0);
    idle(2);
    check("t3_total", bus.LINE_TOTAL, 5);
    check("t3_ok", bus.FRAME_OK, 0);
    drive(0, 1, 1, 16'h0);
    m_sticky = 0;
    @(negedge clk);
    idle(3);
    check("t3_sticky_clr", bus.ERR_STICKY, 0);

    // Checksum wrap and frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    m_fc = 16'hFFFE;
    frame(V, 16'hFFFF, -1, 0);
    frame(V, 16'hFFFF, -1, 0);
    idle(2);
    check("t4_sum", bus.CHECKSUM, 16'hFFE0);
    check("t4_fc", bus.FRAME_CNT, 0);

    // DE held high across the sync: that frame is bad, its open line dropped,
    // and the tail of the line after the sync lands in the next frame as an error.
    idle(2);
    for (int l = 0; l < V; l++) begin
      line(H, -1);
      idle(1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 16'($urandom));
      @(negedge clk);
    end
    drive(1, 0, 0, 16'($urandom));
    model_close(1);
    @(negedge clk);
    px = 16'($urandom);
    drive(1, 0, 0, px);
    cur_sum += px;
    cur_err = 1;
    @(negedge clk);
    px = 16'($urandom);
    drive(1, 1, 0, px);
    cur_sum += px;
    @(negedge clk);
    cur_lines = 1;
    m_len = 2;
    idle(1);
    check("t5_ok", bus.FRAME_OK, 0);
    frame(V, -1, -1, 0);

    // Randomized frames: mostly conforming, with occasional geometry errors and clears.
    for (int f = 0; f < 30; f++) begin
      nl = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? V - 1 : V + 1) : V;
      idle(2);
      if ($urandom_range(0, 4) == 0) begin
        drive(0, 1, 1, 16'h0);
        m_sticky = 0;
        @(negedge clk);
      end
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? H - 1 : H + 1) : H;
        line(len, -1);
        idle($urandom_range(1, 3));
      end
      idle(2);
      close_frame($urandom_range(0, 5) == 0);
    end
    idle(4);

    // Reset in the middle of a line; the next sync must only re-arm.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 16'($urandom));
      @(negedge clk);
    end
    rst = 1;
    drive(0, 1, 0, 16'h0);
    model_reset();
    @(negedge clk);
    check_all_zero("t6_rst");
    @(negedge clk);
    rst = 0;
    idle(3);
    close_frame(0);
    frame(V, 1, -1, 0);
    idle(3);
    check("t6_fc", bus.FRAME_CNT, 1);
    check("t6_sum", bus.CHECKSUM, 16'h0020);

    check("pending_frames", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
